// File: rtl/rob_committer.sv
// In-order commit stage: retires the ROB head entry, writes the register file,
// clears the map table, hands stores to the LSQ and halts on ecall.
module rob_committer #(
    parameter int ROB_SIZE = 16,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     rob_count,
    input  logic            head_ready,
    input  logic [4:0]      head_rd,
    input  logic [XLEN-1:0] head_value,
    input  logic            head_regwr,
    input  logic            head_memwr,
    input  logic            head_ecall,
    input  logic            head_unsupported,
    input  logic            store_ack,
    output logic [31:0]     rob_head,
    output logic            rob_decrement,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            mt_clear,
    output logic [4:0]      mt_reg,
    output logic [31:0]     mt_tag,
    output logic            store_req,
    output logic            halted
);
    typedef enum logic [1:0] {RUN, STORE_WAIT, HALT} state_t;

    state_t          state_reg, state_next;
    logic [31:0]     rob_head_reg, rob_head_next;
    logic            rob_decrement_reg, rob_decrement_next;
    logic            rf_we_reg, rf_we_next;
    logic [4:0]      rf_waddr_reg, rf_waddr_next;
    logic [XLEN-1:0] rf_wdata_reg, rf_wdata_next;
    logic            mt_clear_reg, mt_clear_next;
    logic [4:0]      mt_reg_reg, mt_reg_next;
    logic [31:0]     mt_tag_reg, mt_tag_next;
    logic            store_req_reg, store_req_next;
    logic            halted_reg, halted_next;

    logic        eligible;
    logic [31:0] head_wrapped;

    assign eligible     = (rob_count != 32'd0) && head_ready;
    assign head_wrapped = (rob_head_reg == 32'(ROB_SIZE - 1)) ? 32'd0 : rob_head_reg + 32'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= RUN;
            rob_head_reg      <= '0;
            rob_decrement_reg <= 1'b0;
            rf_we_reg         <= 1'b0;
            rf_waddr_reg      <= '0;
            rf_wdata_reg      <= '0;
            mt_clear_reg      <= 1'b0;
            mt_reg_reg        <= '0;
            mt_tag_reg        <= '0;
            store_req_reg     <= 1'b0;
            halted_reg        <= 1'b0;
        end else begin
            state_reg         <= state_next;
            rob_head_reg      <= rob_head_next;
            rob_decrement_reg <= rob_decrement_next;
            rf_we_reg         <= rf_we_next;
            rf_waddr_reg      <= rf_waddr_next;
            rf_wdata_reg      <= rf_wdata_next;
            mt_clear_reg      <= mt_clear_next;
            mt_reg_reg        <= mt_reg_next;
            mt_tag_reg        <= mt_tag_next;
            store_req_reg     <= store_req_next;
            halted_reg        <= halted_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        rob_head_next      = rob_head_reg;
        rob_decrement_next = 1'b0;
        rf_we_next         = 1'b0;
        rf_waddr_next      = rf_waddr_reg;
        rf_wdata_next      = rf_wdata_reg;
        mt_clear_next      = 1'b0;
        mt_reg_next        = mt_reg_reg;
        mt_tag_next        = mt_tag_reg;
        store_req_next     = store_req_reg;
        halted_next        = halted_reg;

        case (state_reg)
            RUN: begin
                if (eligible) begin
                    if (head_unsupported) begin
                        // Unsupported entries retire silently, even if flagged as stores.
                        rob_head_next      = head_wrapped;
                        rob_decrement_next = 1'b1;
                    end else if (head_memwr) begin
                        state_next     = STORE_WAIT;
                        store_req_next = 1'b1;
                    end else begin
                        rob_head_next      = head_wrapped;
                        rob_decrement_next = 1'b1;
                        if (head_regwr && head_rd != 5'd0) begin
                            rf_we_next    = 1'b1;
                            rf_waddr_next = head_rd;
                            rf_wdata_next = head_value;
                            mt_clear_next = 1'b1;
                            mt_reg_next   = head_rd;
                            // Tags are 1-based: entry i carries tag i+1, no wrap.
                            mt_tag_next   = rob_head_reg + 32'd1;
                        end
                        if (head_ecall) begin
                            state_next  = HALT;
                            halted_next = 1'b1;
                        end
                    end
                end
            end
            STORE_WAIT: begin
                if (store_ack) begin
                    state_next         = RUN;
                    store_req_next     = 1'b0;
                    rob_head_next      = head_wrapped;
                    rob_decrement_next = 1'b1;
                end
            end
            HALT: begin
            end
            default: state_next = RUN;
        endcase
    end

    assign rob_head      = rob_head_reg;
    assign rob_decrement = rob_decrement_reg;
    assign rf_we         = rf_we_reg;
    assign rf_waddr      = rf_waddr_reg;
    assign rf_wdata      = rf_wdata_reg;
    assign mt_clear      = mt_clear_reg;
    assign mt_reg        = mt_reg_reg;
    assign mt_tag        = mt_tag_reg;
    assign store_req     = store_req_reg;
    assign halted        = halted_reg;
endmodule
